// File: rtl/uart_pkg.sv
// Shared UART types and defaults: frame-state and parity-mode encodings,
// default oversampling and prescaler constants, and the 2-of-3 vote helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_CLK_DIV    = 27;

  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// CLK_DIV prescaler producing a one-clk sample tick. A synchronous restart
// realigns the tick phase to an external event such as a start-bit edge.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with mid-bit sampling and a valid/ready output.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around mid-bit.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int CLK_DIV     = DEF_CLK_DIV
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam parity_mode_e PMODE = parity_mode_e'(PARITY_MODE);
  localparam int HALF = OVERSAMPLE / 2;
`ifdef UART_RX_MAJORITY_EN
  // Decide on the last of the three vote ticks; later bits keep the same phase.
  localparam int FIRST_SAMPLE = HALF + 1;
`else
  localparam int FIRST_SAMPLE = HALF;
`endif
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] START_PT = TW'(FIRST_SAMPLE - 1);
  localparam logic [TW-1:0] BIT_PT   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_e state, state_next;

  logic                 sync1, rx_s, rx_prev;
  logic                 tick, start_edge, sample_pt, bit_val;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bad, frame_bad, brk, word_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= data_rx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (start_edge),
    .tick    (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b11;
    end else if (tick) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign bit_val = vote3(hist[1], hist[0], rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (start_edge) state_next = START;
      START:  if (sample_pt) state_next = bit_val ? IDLE : DATA;
      DATA:   if (sample_pt && bit_cnt == LAST_BIT)
                state_next = (PMODE == PAR_NONE) ? STOP : PARITY;
      PARITY: if (sample_pt) state_next = STOP;
      STOP: begin
        // A low stop bit (break) holds here until the line returns high.
        if (brk) begin
          if (rx_s) state_next = IDLE;
        end else if (sample_pt) begin
          if (bit_cnt != '0) state_next = IDLE;
          else if (bit_val && STOP_BITS == 1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    start_edge = (state == IDLE) && rx_prev && !rx_s;
    sample_pt  = 1'b0;
    if (tick) begin
      unique case (state)
        START:        sample_pt = (tick_cnt == START_PT);
        DATA, PARITY: sample_pt = (tick_cnt == BIT_PT);
        STOP:         sample_pt = !brk && (tick_cnt == BIT_PT);
        default:      sample_pt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bad   <= 1'b0;
      frame_bad <= 1'b0;
      brk       <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (start_edge || sample_pt) begin
        tick_cnt <= '0;
      end else if (tick && busy) begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      if (sample_pt) begin
        bit_cnt <= ((state == DATA && bit_cnt != LAST_BIT) || state == STOP) ?
                   bit_cnt + 1'b1 : '0;
      end
      if (start_edge) par_bad <= 1'b0;
      if (state == IDLE) brk <= 1'b0;
      if (sample_pt) begin
        unique case (state)
          DATA:   shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
          PARITY: par_bad <= ((^shift_reg) ^ bit_val) != (PMODE == PAR_ODD);
          STOP: begin
            if (bit_cnt == '0) begin
              frame_bad <= !bit_val;
              brk       <= !bit_val;
              word_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (word_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift_reg;
          rx_valid   <= 1'b1;
          parity_err <= par_bad;
          frame_err  <= frame_bad;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations share one clock,
// expected words are queued at send time and compared when delivered.
module tb_uart_rx_param;

  localparam int OS  = 16;
  localparam int DIV = 4;
  localparam int BIT = OS * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] line, ready, valid, perr, ferr, ovr, busy;
  logic [7:0] d0, d1;
  logic [4:0] d2;

  int checks = 0;
  int errors = 0;
  int ovr_cnt [3];

  typedef struct {
    int         ch;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(OS), .CLK_DIV(DIV)) u0 (
    .clk(clk), .rst_n(rst_n), .data_rx(line[0]), .rx_data(d0), .rx_valid(valid[0]),
    .rx_ready(ready[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun_err(ovr[0]), .busy(busy[0]));

  uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .OVERSAMPLE(OS), .CLK_DIV(DIV)) u1 (
    .clk(clk), .rst_n(rst_n), .data_rx(line[1]), .rx_data(d1), .rx_valid(valid[1]),
    .rx_ready(ready[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun_err(ovr[1]), .busy(busy[1]));

  uart_rx_param #(.DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(2), .OVERSAMPLE(OS), .CLK_DIV(DIV)) u2 (
    .clk(clk), .rst_n(rst_n), .data_rx(line[2]), .rx_data(d2), .rx_valid(valid[2]),
    .rx_ready(ready[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun_err(ovr[2]), .busy(busy[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (ovr[i] === 1'b1) ovr_cnt[i]++;
  end

  function automatic logic [8:0] rd(input int ch);
    case (ch)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      default: return {4'b0, d2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int ch, input logic [8:0] data, input int nbits, input int pmode,
                      input bit flip_par, input bit stop_low, input int nstop, input bit push);
    exp_t e;
    logic p;
    if (push) begin
      e.ch = ch; e.data = data; e.perr = (pmode != 0) && flip_par; e.ferr = stop_low;
      exp_q.push_back(e);
    end
    p = (pmode == 2);
    line[ch] = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      line[ch] = data[i];
      p = p ^ data[i];
      repeat (BIT) @(posedge clk);
    end
    if (pmode != 0) begin
      line[ch] = p ^ flip_par;
      repeat (BIT) @(posedge clk);
    end
    for (int s = 0; s < nstop; s++) begin
      line[ch] = !stop_low;
      repeat (BIT) @(posedge clk);
    end
  endtask

  task automatic expect_word(input int ch);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (valid[ch] !== 1'b1 && n < 20 * BIT) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("valid_ch%0d", ch), 9'(valid[ch]), 9'd1);
    if (valid[ch] !== 1'b1) return;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow ch%0d observed=0x%0h expected=none", ch, rd(ch));
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("data_ch%0d", ch), rd(ch), e.data);
    check($sformatf("perr_ch%0d", ch), 9'(perr[ch]), 9'(e.perr));
    check($sformatf("ferr_ch%0d", ch), 9'(ferr[ch]), 9'(e.ferr));
    ready[ch] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready[ch] = 1'b0;
    check($sformatf("valid_fall_ch%0d", ch), 9'(valid[ch]), 9'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    line = '1;
    ready = '0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int ch = 0; ch < 3; ch++) begin
      check($sformatf("rst_valid_ch%0d", ch), 9'(valid[ch]), 9'd0);
      check($sformatf("rst_busy_ch%0d", ch), 9'(busy[ch]), 9'd0);
      check($sformatf("rst_data_ch%0d", ch), rd(ch), 9'd0);
      check($sformatf("rst_err_ch%0d", ch), 9'({perr[ch], ferr[ch], ovr[ch]}), 9'd0);
    end

    // Defaults, flipped even parity, correct odd parity
    send(0, 9'hA5, 8, 1, 1'b0, 1'b0, 1, 1'b1);
    expect_word(0);
    send(0, 9'h3C, 8, 1, 1'b1, 1'b0, 1, 1'b1);
    expect_word(0);
    send(1, 9'h3C, 8, 2, 1'b0, 1'b0, 1, 1'b1);
    expect_word(1);

    // Break: stop bit low, line held low for 20 bit times
    send(0, 9'h55, 8, 1, 1'b0, 1'b1, 1, 1'b1);
    expect_word(0);
    repeat (20 * BIT) @(negedge clk);
    check("break_no_word", 9'(valid[0]), 9'd0);
    check("break_busy", 9'(busy[0]), 9'd1);
    line[0] = 1'b1;
    repeat (BIT) @(negedge clk);
    check("break_idle", 9'(busy[0]), 9'd0);

    // Overrun: second word dropped while first is held
    c = ovr_cnt[0];
    send(0, 9'h11, 8, 1, 1'b0, 1'b0, 1, 1'b1);
    send(0, 9'h22, 8, 1, 1'b0, 1'b0, 1, 1'b0);
    @(negedge clk);
    check("ovr_once", 9'(ovr_cnt[0] - c), 9'd1);
    check("ovr_held", rd(0), 9'h11);
    expect_word(0);

    // False start from a short glitch
    line[0] = 1'b0;
    repeat (OS / 4 * DIV) @(negedge clk);
    line[0] = 1'b1;
    check("glitch_busy", 9'(busy[0]), 9'd1);
    repeat (BIT) @(negedge clk);
    check("glitch_idle", 9'(busy[0]), 9'd0);
    check("glitch_no_word", 9'(valid[0]), 9'd0);

    // Reset mid-frame
    line[0] = 1'b0;
    repeat (BIT) @(negedge clk);
    line[0] = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    check("mid_busy", 9'(busy[0]), 9'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 9'(busy[0]), 9'd0);
    check("mid_rst_data", rd(0), 9'd0);
    check("mid_rst_flags", 9'({valid[0], perr[0], ferr[0], ovr[0]}), 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("post_rst_busy", 9'(busy[0]), 9'd0);
    check("post_rst_valid", 9'(valid[0]), 9'd0);

    // 5-bit, no parity, 2 stop bits, back-to-back
    fork
      begin
        send(2, 9'h1F, 5, 0, 1'b0, 1'b0, 2, 1'b1);
        send(2, 9'h0A, 5, 0, 1'b0, 1'b0, 2, 1'b1);
        line[2] = 1'b1;
      end
      begin
        expect_word(2);
        expect_word(2);
      end
    join

`ifdef UART_RX_MAJORITY_EN
    begin
      exp_t e;
      e.ch = 2; e.data = 9'h15; e.perr = 1'b0; e.ferr = 1'b0;
      exp_q.push_back(e);
      line[2] = 1'b0;
      repeat (BIT) @(posedge clk);
      for (int i = 0; i < 5; i++) begin
        line[2] = e.data[i];
        repeat (BIT / 2) @(posedge clk);
        line[2] = !e.data[i];
        repeat (DIV) @(posedge clk);
        line[2] = e.data[i];
        repeat (BIT / 2 - DIV) @(posedge clk);
      end
      line[2] = 1'b1;
      repeat (2 * BIT) @(posedge clk);
      expect_word(2);
    end
`endif

    check("sb_empty", 9'(exp_q.size()), 9'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
